rf_wport_arbiter: RTL and testbench
===================================

RF_WPORT_ARBITER -- requirements
Module: rf_wport_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, register data width.
REQ-002 SHALL have parameter AW, default 5, register address width (32 registers, r0 hardwired zero).
REQ-003 SHALL have parameter CW, default 16, statistics counter width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req0_valid/req1_valid  input  1  write request from requester 0/1.
REQ-007 SHALL have ports req0_addr/req1_addr  input  AW  destination register.
REQ-008 SHALL have ports req0_data/req1_data  input  DW  write data.
REQ-009 SHALL have ports req0_ready/req1_ready  output  1  request accepted this cycle.
REQ-010 SHALL have port hold  input  1  freeze; no request accepted while high.
REQ-011 SHALL have ports rf_wen, rf_waddr, rf_wdata  output  1/AW/DW  registered regfile write port.
REQ-012 SHALL have ports raddr1/raddr2  input  AW, rf_rdata1/rf_rdata2  input  DW  regfile read side.
REQ-013 SHALL have ports fwd_rdata1/fwd_rdata2  output  DW  read data with write forwarding.
REQ-014 SHALL have ports wr_count, conflict_count  output  CW  statistics.

Function
REQ-015 SHALL complete a transfer on reqN when reqN_valid && reqN_ready in the same cycle; readyN combinational from valids, hold, rr_ptr.
REQ-016 SHALL drive both readys 0 while hold=1, regardless of valids.
REQ-017 SHALL grant the sole valid requester when exactly one valid and hold=0.
REQ-018 SHALL grant requester rr_ptr when both valid and hold=0; the other's ready stays 0.
REQ-019 SHALL set rr_ptr to the non-granted index after every accepted transfer (single or contended).
REQ-020 SHALL never assert both readys in one cycle; a stalled valid requester is granted within 2 cycles of contention (no starvation).
REQ-021 SHALL register the accepted request: cycle after acceptance, rf_wen=1, rf_waddr/rf_wdata = granted addr/data (latency 1).
REQ-022 SHALL drive rf_wen=0 in the following cycle for an accepted request with addr 0 (consumed, not written); rf_waddr/rf_wdata still load.
REQ-023 SHALL drive rf_wen=0 in any cycle not following an acceptance; rf_waddr/rf_wdata hold last value.
REQ-024 SHALL compute fwd_rdataK = rf_wdata when rf_wen && rf_waddr==raddrK && raddrK!=0, else rf_rdataK (combinational).
REQ-025 SHALL increment wr_count each cycle rf_wen=1, saturating at all-ones.
REQ-026 SHALL increment conflict_count each cycle both valid and hold=0, saturating at all-ones.

Reset
REQ-027 SHALL on resetn=0 immediately force rf_wen=0, rf_waddr=0, rf_wdata=0, rr_ptr=0, wr_count=0, conflict_count=0.
REQ-028 SHALL discard any registered write when reset asserts mid-operation; requests are accepted from the first clock edge after deassertion.

Structure
REQ-029 SHALL place DW/AW/CW defaults and the requester-index constants (REQ0=0, REQ1=1) in a shared package.
REQ-030 SHALL implement the grant/rr_ptr logic in one sub-module rr_arb2; forwarding, output register and counters in the top.

Verification
REQ-031 SHALL test single request: req0 valid addr 3 data 0x1234 -> req0_ready=1 same cycle; next cycle rf_wen=1, waddr 3, wdata 0x1234; wr_count=1.
REQ-032 SHALL test contention: both valid for 4 cycles after reset (req0 addr 1, req1 addr 2) -> grants 0,1,0,1; conflict_count=4.
REQ-033 SHALL test hold: both valid, hold=1 for 3 cycles -> readys 0, rf_wen 0; first grant after release to rr_ptr value.
REQ-034 SHALL test r0 write: req1 addr 0 data 0xFFFF_FFFF -> ready=1, next cycle rf_wen=0, wr_count unchanged.
REQ-035 SHALL test forwarding: rf_wen=1 waddr 5 wdata 0xA5A5_A5A5, raddr1=5, raddr2=6, rf_rdata1=0 -> fwd_rdata1=0xA5A5_A5A5, fwd_rdata2=rf_rdata2; raddr1=0 -> rf_rdata1.
REQ-036 SHALL test reset mid-write: resetn low during rf_wen=1 cycle -> rf_wen=0 immediately, counters 0, rr_ptr 0.

Source files
------------

// File: rtl/rf_wport_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Holds the width defaults and the requester index encoding.
package rf_wport_arbiter_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;
    localparam int CW_DEF = 16;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic {
        PTR_REQ0 = REQ0,
        PTR_REQ1 = REQ1
    } rr_ptr_e;

endpackage

// File: rtl/rf_wport_arbiter_rr_arb2.sv
// Two-way round-robin grant for the regfile write port.
// The pointer names who wins the next contended cycle.
module rr_arb2
    import rf_wport_arbiter_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic hold,
    input  logic valid0,
    input  logic valid1,
    output logic ready0,
    output logic ready1,
    output logic contend
);

    rr_ptr_e ptr_q;
    rr_ptr_e ptr_d;

    // Pointer register, cleared to requester 0 on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= PTR_REQ0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Grant decision and pointer advance to the loser of each transfer.
    always_comb begin
        ready0  = 1'b0;
        ready1  = 1'b0;
        ptr_d   = ptr_q;
        contend = valid0 && valid1 && !hold;

        if (!hold) begin
            if (valid0 && valid1) begin
                unique case (ptr_q)
                    PTR_REQ0: ready0 = 1'b1;
                    PTR_REQ1: ready1 = 1'b1;
                    default:  ready0 = 1'b1;
                endcase
            end else begin
                ready0 = valid0;
                ready1 = valid1;
            end
        end

        if (ready0) begin
            ptr_d = PTR_REQ1;
        end else if (ready1) begin
            ptr_d = PTR_REQ0;
        end
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Regfile write-port arbiter: two requesters share one registered
// write port, with read forwarding and saturating statistics.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    input  logic          hold,
    output logic          rf_wen,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    input  logic [DW-1:0] rf_rdata1,
    input  logic [DW-1:0] rf_rdata2,
    output logic [DW-1:0] fwd_rdata1,
    output logic [DW-1:0] fwd_rdata2,
    output logic [CW-1:0] wr_count,
    output logic [CW-1:0] conflict_count
);

    logic          contend;
    logic          accept;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_data;

    rr_arb2 u_arb (
        .clk     (clk),
        .resetn  (resetn),
        .hold    (hold),
        .valid0  (req0_valid),
        .valid1  (req1_valid),
        .ready0  (req0_ready),
        .ready1  (req1_ready),
        .contend (contend)
    );

    // Select the granted requester's payload.
    always_comb begin
        accept = req0_ready || req1_ready;
        g_addr = req0_addr;
        g_data = req0_data;
        if (req1_ready) begin
            g_addr = req1_addr;
            g_data = req1_data;
        end
    end

    // Write port register; r0 writes are consumed but never enabled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= accept && (g_addr != '0);
            if (accept) begin
                rf_waddr <= g_addr;
                rf_wdata <= g_data;
            end
        end
    end

    // Saturating counters for committed writes and contended cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_count       <= '0;
            conflict_count <= '0;
        end else begin
            if (rf_wen && (wr_count != '1)) begin
                wr_count <= wr_count + CW'(1);
            end
            if (contend && (conflict_count != '1)) begin
                conflict_count <= conflict_count + CW'(1);
            end
        end
    end

    // Bypass the pending write onto matching non-zero read ports.
    always_comb begin
        fwd_rdata1 = rf_rdata1;
        fwd_rdata2 = rf_rdata2;
        if (rf_wen && (rf_waddr == raddr1) && (raddr1 != '0)) begin
            fwd_rdata1 = rf_wdata;
        end
        if (rf_wen && (rf_waddr == raddr2) && (raddr2 != '0)) begin
            fwd_rdata2 = rf_wdata;
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: directed literal checks plus a
// randomized run compared every cycle against a behavioural model.
module tb_rf_wport_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          req0_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_data = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_data = '0;
    logic          req1_ready;
    logic          hold = 1'b0;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] raddr1 = '0;
    logic [AW-1:0] raddr2 = '0;
    logic [DW-1:0] rf_rdata1 = '0;
    logic [DW-1:0] rf_rdata2 = '0;
    logic [DW-1:0] fwd_rdata1;
    logic [DW-1:0] fwd_rdata2;
    logic [CW-1:0] wr_count;
    logic [CW-1:0] conflict_count;

    rf_wport_arbiter #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .req0_valid     (req0_valid),
        .req0_addr      (req0_addr),
        .req0_data      (req0_data),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_addr      (req1_addr),
        .req1_data      (req1_data),
        .req1_ready     (req1_ready),
        .hold           (hold),
        .rf_wen         (rf_wen),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .raddr1         (raddr1),
        .raddr2         (raddr2),
        .rf_rdata1      (rf_rdata1),
        .rf_rdata2      (rf_rdata2),
        .fwd_rdata1     (fwd_rdata1),
        .fwd_rdata2     (fwd_rdata2),
        .wr_count       (wr_count),
        .conflict_count (conflict_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Behavioural model: who wins, and what the port shows next cycle.
    int            m_ptr;
    logic          m_wen;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    int            m_wr;
    int            m_cf;
    int            g_now;

    function automatic int grant_of(input logic v0, input logic v1,
                                    input logic h, input int ptr);
        if (h) return -1;
        if (v0 && v1) return ptr;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    function automatic logic [DW-1:0] m_fwd(input logic [AW-1:0] ra,
                                            input logic [DW-1:0] rd);
        if (m_wen && m_waddr == ra && ra != 0) return m_wdata;
        return rd;
    endfunction

    assign g_now = grant_of(req0_valid, req1_valid, hold, m_ptr);

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_ptr   <= 0;
            m_wen   <= 1'b0;
            m_waddr <= '0;
            m_wdata <= '0;
            m_wr    <= 0;
            m_cf    <= 0;
        end else begin
            if (g_now >= 0) begin
                m_ptr   <= 1 - g_now;
                m_waddr <= (g_now == 0) ? req0_addr : req1_addr;
                m_wdata <= (g_now == 0) ? req0_data : req1_data;
            end
            m_wen <= (g_now >= 0) &&
                     (((g_now == 0) ? req0_addr : req1_addr) != 0);
            m_wr  <= (m_wen && m_wr < CMAX) ? m_wr + 1 : m_wr;
            m_cf  <= (req0_valid && req1_valid && !hold && m_cf < CMAX)
                     ? m_cf + 1 : m_cf;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (resetn) begin
            chk("ready0", 64'(req0_ready), 64'(g_now == 0));
            chk("ready1", 64'(req1_ready), 64'(g_now == 1));
            chk("one_ready", 64'(req0_ready & req1_ready), 64'(0));
            chk("rf_wen", 64'(rf_wen), 64'(m_wen));
            chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
            chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
            chk("wr_count", 64'(wr_count), 64'(m_wr));
            chk("conflict_count", 64'(conflict_count), 64'(m_cf));
            chk("fwd1", 64'(fwd_rdata1), 64'(m_fwd(raddr1, rf_rdata1)));
            chk("fwd2", 64'(fwd_rdata2), 64'(m_fwd(raddr2, rf_rdata2)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        hold       = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle();
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        do_reset();

        // Single request, latency one, then counted.
        req0_valid = 1'b1;
        req0_addr  = 5'd3;
        req0_data  = 32'h1234;
        #1;
        chk("single_ready0", 64'(req0_ready), 64'(1));
        chk("single_ready1", 64'(req1_ready), 64'(0));
        tick();
        idle();
        chk("single_wen", 64'(rf_wen), 64'(1));
        chk("single_waddr", 64'(rf_waddr), 64'(3));
        chk("single_wdata", 64'(rf_wdata), 64'h1234);
        tick();
        chk("single_wr_count", 64'(wr_count), 64'(1));

        // Contention from reset alternates 0,1,0,1.
        do_reset();
        req0_valid = 1'b1;
        req0_addr  = 5'd1;
        req0_data  = 32'hAAAA_0001;
        req1_valid = 1'b1;
        req1_addr  = 5'd2;
        req1_data  = 32'hBBBB_0002;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready0", 64'(req0_ready), 64'(i % 2 == 0));
            chk("rr_ready1", 64'(req1_ready), 64'(i % 2 == 1));
            tick();
        end
        idle();
        chk("rr_conflicts", 64'(conflict_count), 64'(4));

        // Hold blocks both, does not count, then grants the pointer.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        hold       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_ready0", 64'(req0_ready), 64'(0));
            chk("hold_ready1", 64'(req1_ready), 64'(0));
            tick();
            chk("hold_wen", 64'(rf_wen), 64'(0));
        end
        chk("hold_conflicts", 64'(conflict_count), 64'(4));
        hold = 1'b0;
        #1;
        chk("release_ready0", 64'(req0_ready), 64'(1));
        chk("release_ready1", 64'(req1_ready), 64'(0));
        tick();
        idle();

        // r0 write is consumed without enabling the port.
        do_reset();
        req1_valid = 1'b1;
        req1_addr  = 5'd0;
        req1_data  = 32'hFFFF_FFFF;
        #1;
        chk("r0_ready1", 64'(req1_ready), 64'(1));
        tick();
        idle();
        chk("r0_wen", 64'(rf_wen), 64'(0));
        chk("r0_wdata", 64'(rf_wdata), 64'hFFFF_FFFF);
        tick();
        chk("r0_wr_count", 64'(wr_count), 64'(0));

        // Forwarding, with one earlier contended write in flight.
        do_reset();
        req0_valid = 1'b1;
        req0_addr  = 5'd7;
        req0_data  = 32'h7777_7777;
        req1_valid = 1'b1;
        req1_addr  = 5'd9;
        req1_data  = 32'h9999_9999;
        tick();
        req1_valid = 1'b0;
        req0_addr  = 5'd5;
        req0_data  = 32'hA5A5_A5A5;
        tick();
        idle();
        raddr1    = 5'd5;
        raddr2    = 5'd6;
        rf_rdata1 = 32'h0;
        rf_rdata2 = 32'h1111_2222;
        #1;
        chk("fwd_hit1", 64'(fwd_rdata1), 64'hA5A5_A5A5);
        chk("fwd_miss2", 64'(fwd_rdata2), 64'h1111_2222);
        raddr1    = 5'd0;
        rf_rdata1 = 32'h3333;
        raddr2    = 5'd5;
        #1;
        chk("fwd_r0", 64'(fwd_rdata1), 64'h3333);
        chk("fwd_hit2", 64'(fwd_rdata2), 64'hA5A5_A5A5);
        chk("pre_rst_wen", 64'(rf_wen), 64'(1));
        chk("pre_rst_wr", 64'(wr_count), 64'(1));
        chk("pre_rst_cf", 64'(conflict_count), 64'(1));

        // Reset mid-write clears immediately; pointer back to 0.
        resetn = 1'b0;
        #1;
        chk("rst_wen", 64'(rf_wen), 64'(0));
        chk("rst_waddr", 64'(rf_waddr), 64'(0));
        chk("rst_wdata", 64'(rf_wdata), 64'(0));
        chk("rst_wr", 64'(wr_count), 64'(0));
        chk("rst_cf", 64'(conflict_count), 64'(0));
        tick();
        tick();
        resetn     = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_addr  = 5'd4;
        req1_addr  = 5'd8;
        #1;
        chk("rst_ptr_ready0", 64'(req0_ready), 64'(1));
        chk("rst_ptr_ready1", 64'(req1_ready), 64'(0));

        // Saturation of both counters.
        for (int i = 0; i < CMAX + 8; i++) tick();
        idle();
        chk("sat_wr", 64'(wr_count), 64'(CMAX));
        chk("sat_cf", 64'(conflict_count), 64'(CMAX));

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(499) == 0) begin
                resetn = 1'b0;
            end else begin
                resetn = 1'b1;
            end
            req0_valid = ($urandom_range(9) < 7);
            req1_valid = ($urandom_range(9) < 7);
            hold       = ($urandom_range(19) < 3);
            req0_addr  = AW'($urandom);
            req1_addr  = AW'($urandom);
            req0_data  = $urandom;
            req1_data  = $urandom;
            raddr1     = ($urandom_range(1) == 0) ? rf_waddr : AW'($urandom);
            raddr2     = ($urandom_range(1) == 0) ? rf_waddr : AW'($urandom);
            rf_rdata1  = $urandom;
            rf_rdata2  = $urandom;
            tick();
        end
        resetn = 1'b1;
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
